// File: rtl/mpmod_reduce.sv
// mpmod_reduce: conditional-subtract reduction after the 128-bit multi-precision
// adder. Returns R = C - M when C >= M, else R = C. A single 64-bit subtractor
// with a registered borrow handles one limb per cycle (low limb, then high
// limb). A final select cycle then picks the difference or the pass-through value.
module mpmod_reduce (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [128:0] C,
  input  logic [127:0] M,
  output logic [127:0] R,
  output logic         done,
  output logic         busy
);

  localparam int unsigned LIMB = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB_LO = 2'd1,
    SUB_HI = 2'd2,
    SEL    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [128:0]    r_c;
  logic [127:0]    r_m;
  logic [127:0]    r_d;
  logic            r_borrow;
  logic [127:0]    r_r;
  logic            r_done;

  logic [LIMB-1:0] w_op_c;
  logic [LIMB-1:0] w_op_m;
  logic            w_bin;
  logic [LIMB:0]   w_sub;
  logic [LIMB-1:0] w_diff;
  logic            w_bout;
  logic            w_final_borrow;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: one pass through the limbs, then select and return to IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SUB_LO;
      SUB_LO:  w_next = SUB_HI;
      SUB_HI:  w_next = SEL;
      SEL:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand selection for the shared limb subtractor
  always_comb begin
    w_op_c = '0;
    w_op_m = '0;
    w_bin  = 1'b0;
    unique case (r_state)
      SUB_LO: begin
        w_op_c = r_c[LIMB-1:0];
        w_op_m = r_m[LIMB-1:0];
        w_bin  = 1'b0;
      end
      SUB_HI: begin
        w_op_c = r_c[2*LIMB-1:LIMB];
        w_op_m = r_m[2*LIMB-1:LIMB];
        w_bin  = r_borrow;
      end
      default: begin
        w_op_c = '0;
        w_op_m = '0;
        w_bin  = 1'b0;
      end
    endcase
  end

  // The 65-bit two's-complement difference puts the borrow in the top bit
  assign w_sub  = {1'b0, w_op_c} - {1'b0, w_op_m} - {{LIMB{1'b0}}, w_bin};
  assign w_diff = w_sub[LIMB-1:0];
  assign w_bout = w_sub[LIMB];

  // C's carry bit absorbs a borrow out of the high limb
  assign w_final_borrow = r_borrow & ~r_c[128];

  // Datapath: capture operands, accumulate the limb differences, then select the result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_c      <= '0;
      r_m      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_r      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_c <= C;
            r_m <= M;
          end
        end
        SUB_LO: begin
          r_d[LIMB-1:0] <= w_diff;
          r_borrow      <= w_bout;
        end
        SUB_HI: begin
          r_d[2*LIMB-1:LIMB] <= w_diff;
          r_borrow           <= w_bout;
        end
        SEL: begin
          r_r    <= w_final_borrow ? r_c[127:0] : r_d;
          r_done <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign R    = r_r;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule

// File: doc/mpmod_reduce.md
# mpmod_reduce

Conditional-subtract reduction stage that sits directly downstream of the 128-bit multi-precision adder. It consumes the adder's 129-bit sum C and a 128-bit modulus M, and returns R = C − M when C ≥ M, otherwise R = C. Together with the adder it forms a modular adder. It reuses the adder's datapath style: one 64-bit subtractor with a registered borrow, two limb cycles, and a small FSM.

## Interface
- No parameters; widths fixed: limb 64, operand 128, sum input 129.
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  reset, synchronous, active-low
- start  input  1  request pulse; sampled only in IDLE
- C  input  129  unreduced sum (adder output); sampled with start
- M  input  128  modulus; sampled with start
- R  output  128  reduced result; registered, held until the next completion
- done  output  1  registered one-cycle pulse; R is valid in the same cycle
- busy  output  1  high in SUB_LO, SUB_HI, SEL

## Operation
- Input registers regC (129 b) and regM (128 b) load when state = IDLE and start = 1. They are not loaded otherwise.
- Subtractor: {borrow_out, diff[63:0]} = opC − opM − borrow_in, computed as a 65-bit two's-complement result.
- borrow_in is 0 in SUB_LO and the registered borrow in SUB_HI.
- SUB_LO: opC = regC[63:0], opM = regM[63:0]. Write diff to regD[63:0] and borrow_out to regBorrow.
- SUB_HI: opC = regC[127:64], opM = regM[127:64], borrow_in = regBorrow. Write diff to regD[127:64] and borrow_out to regBorrow.
- SEL: final_borrow = regBorrow & ~regC[128].
  - If final_borrow = 1 (C < M): R ← regC[127:0].
  - Otherwise: R ← regD.
  - Set done ← 1.
- If C ≥ 2M, R is the low 128 bits of C − M. No second subtraction is done; callers guarantee C < 2M for a fully reduced result.
- States: IDLE(0), SUB_LO(1), SUB_HI(2), SEL(3), 2-bit state register.
  - IDLE → SUB_LO on start; otherwise stay in IDLE.
  - SUB_LO → SUB_HI → SEL unconditionally.
  - SEL → IDLE.
- start while busy is ignored: no reload, and the ongoing result is unaffected.

## Timing
- Reset values: state = IDLE; R = 0; done = 0; busy = 0; regC, regM, regD, regBorrow = 0.
- Let edge k be the edge that samples start = 1 in IDLE:
  - Edge k+1 completes SUB_LO.
  - Edge k+2 completes SUB_HI.
  - Edge k+3 writes R and sets done.
- done is high for exactly one cycle, between edges k+3 and k+4. Latency is 3 cycles from the accepting edge.
- Throughput: one operation per 4 cycles.
- start asserted in the cycle where done = 1 is accepted, because the state is IDLE then. R keeps the previous result until that new operation's SEL edge.
- busy is combinational from state and goes low in the done cycle.
- resetn = 0 at any edge, including mid-operation:
  - All registers return to reset values on that edge.
  - No done pulse is produced for the aborted operation.
- The adder's C and done connect directly: adder done → start, adder C → C. M must be stable in the same cycle.

## Test plan
- C=5, M=3, start pulse at edge k -> done=1 only after edge k+3, R=2; busy high for exactly 3 cycles.
- C=2, M=3 -> R=2 (C<M passes through); C=3, M=3 -> R=0 (equality subtracts).
- Cross-limb borrow: C=2^64, M=1 -> R=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Carry bit used: C=2^128 (C[128]=1, rest 0), M=2^127 -> R=2^127 (high-limb borrow cancelled by C[128]). Also C=2^128+5, M=2^128−1 -> R=6.
- Start held high for 8 cycles with C=10, M=4, then C changed to 100 at edge k+1 -> first result R=6 with one done pulse; a second operation is accepted in the done cycle, using C and M as sampled in that cycle.
- resetn=0 at edge k+2 of an operation -> no done pulse, R=0, busy=0. A new start after reset returns a correct result.
